// File: rtl/dvr_fifo_if.sv
// DVR (data/valid/rdy) stream interface shared by the aes_encrypter datapath stages.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 32
);
    logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
    logic                             valid;
    logic                             rdy;

    modport master (output data, output valid, input rdy);
    modport slave  (input data, input valid, output rdy);
endinterface

// File: rtl/dvr_fifo.sv
// First-word-fall-through FIFO between two DVR stream ports, with fill level and almost-full.
// Define DVR_FIFO_FLUSH_EN to add a synchronous flush input.
module dvr_fifo #(
    parameter int DATA_WIDTH_IN_BYTES = 32,
    parameter int DEPTH               = 8,
    parameter int ALMOST_FULL_THRESH  = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    avalon_st_if.slave               msg_in,
    avalon_st_if.master              msg_out,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     almost_full
`ifdef DVR_FIFO_FLUSH_EN
    ,
    input  logic                     flush
`endif
);
    localparam int W  = DATA_WIDTH_IN_BYTES * 8;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          rdy_q, af_q, push, pop, clr;

`ifdef DVR_FIFO_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    assign push = msg_in.valid && rdy_q;
    assign pop  = (count != '0) && msg_out.rdy;

    // Flush wins over any handshake in the same cycle, including a completed push.
    always_comb begin
        count_next = count + CW'(push) - CW'(pop);
        if (clr)
            count_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_q  <= 1'b0;
            af_q   <= 1'b0;
        end else begin
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            rdy_q <= (count_next != CW'(DEPTH));
            af_q  <= (count_next >= CW'(ALMOST_FULL_THRESH));
        end
    end

    // Storage is deliberately left unreset; the read mux masks stale entries.
    always_ff @(posedge clk) begin
        if (push && !clr)
            mem[wr_ptr] <= msg_in.data;
    end

    assign msg_in.rdy    = rdy_q;
    assign msg_out.valid = (count != '0);
    assign msg_out.data  = (count != '0) ? mem[rd_ptr] : '0;
    assign fill_level    = count;
    assign almost_full   = af_q;
endmodule

// File: tb/tb_dvr_fifo.sv
// Directed bench for dvr_fifo with a queue model checked every cycle on the falling edge.
module tb_dvr_fifo;
    localparam int DW    = 4;
    localparam int DEPTH = 8;
    localparam int AFT   = 6;
    localparam int W     = DW * 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(DW)) in_if ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(DW)) out_if ();
    logic [3:0] fill_level;
    logic       almost_full;
`ifdef DVR_FIFO_FLUSH_EN
    logic       flush = 1'b0;
`endif

    dvr_fifo #(.DATA_WIDTH_IN_BYTES(DW), .DEPTH(DEPTH), .ALMOST_FULL_THRESH(AFT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .msg_in      (in_if),
        .msg_out     (out_if),
        .fill_level  (fill_level),
        .almost_full (almost_full)
`ifdef DVR_FIFO_FLUSH_EN
        ,
        .flush       (flush)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Model: the FIFO contents as a plain queue plus the producer-side ready.
    logic [W-1:0] q[$];
    logic         m_rdy;
    bit           m_push, m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_rdy = 1'b0;
        end else begin
            m_push = in_if.valid && m_rdy;
            m_pop  = (q.size() != 0) && out_if.rdy;
`ifdef DVR_FIFO_FLUSH_EN
            if (flush) begin
                q.delete();
                m_rdy = 1'b1;
            end else
`endif
            begin
                if (m_pop)  void'(q.pop_front());
                if (m_push) q.push_back(in_if.data);
                m_rdy = (q.size() != DEPTH);
            end
        end
    end

    logic [W-1:0] exp_data;
    always @(negedge clk) begin
        exp_data = (q.size() != 0) ? q[0] : '0;
        chk("rdy",   in_if.rdy,    m_rdy);
        chk("valid", out_if.valid, q.size() != 0);
        chk("data",  out_if.data,  exp_data);
        chk("fill",  fill_level,   q.size());
        chk("afull", almost_full,  q.size() >= AFT);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_if.valid = 1'b0;
        in_if.data  = '0;
        out_if.rdy  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy",   in_if.rdy,    0);
        chk("rst_valid", out_if.valid, 0);
        chk("rst_data",  out_if.data,  0);
        chk("rst_fill",  fill_level,   0);
        rst_n = 1'b1;
        chk("rdy_held_low", in_if.rdy, 0);
        step();
        chk("rdy_after_release", in_if.rdy, 1);

        // Fill to full with the consumer stalled.
        for (int i = 1; i <= 8; i++) begin
            in_if.valid = 1'b1;
            in_if.data  = i;
            step();
            if (i == 5) chk("afull_at5", almost_full, 0);
            if (i == 6) chk("afull_at6", almost_full, 1);
        end
        chk("full_fill", fill_level, 8);
        chk("full_rdy",  in_if.rdy,  0);
        in_if.data = 32'hDEADBEEF;
        repeat (2) step();
        chk("full_reject_fill", fill_level, 8);
        in_if.valid = 1'b0;

        // Drain in order.
        out_if.rdy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", out_if.data, i);
            step();
        end
        chk("drain_empty", out_if.valid, 0);

        // Continuous streaming through an otherwise empty FIFO; pointers wrap.
        for (int k = 0; k < 20; k++) begin
            in_if.valid = 1'b1;
            in_if.data  = 32'h100 + k;
            step();
            chk("stream_fill", fill_level, 1);
            chk("stream_data", out_if.data, 32'h100 + k);
        end
        in_if.valid = 1'b0;
        step();
        chk("stream_empty", out_if.valid, 0);

        // Simultaneous push/pop at fill level 4.
        out_if.rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_if.valid = 1'b1;
            in_if.data  = 32'h200 + k;
            step();
        end
        chk("sim_pre_fill", fill_level, 4);
        out_if.rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_if.data = 32'h300 + k;
            step();
            chk("sim_fill",  fill_level,  4);
            chk("sim_afull", almost_full, 0);
            chk("sim_data",  out_if.data, (k < 3) ? 32'h201 + k : 32'h300 + k - 3);
        end
        in_if.valid = 1'b0;
        repeat (4) step();
        chk("sim_empty", out_if.valid, 0);

        // Backpressure hold.
        out_if.rdy  = 1'b0;
        in_if.valid = 1'b1;
        in_if.data  = 32'hA5A5A5A5;
        step();
        in_if.valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_data",  out_if.data,  32'hA5A5A5A5);
            chk("hold_valid", out_if.valid, 1);
            chk("hold_fill",  fill_level,   1);
        end
        out_if.rdy = 1'b1;
        step();
        chk("hold_empty", out_if.valid, 0);

`ifdef DVR_FIFO_FLUSH_EN
        out_if.rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_if.valid = 1'b1;
            in_if.data  = 32'h400 + k;
            step();
        end
        chk("flush_pre_fill", fill_level, 5);
        flush       = 1'b1;
        in_if.data  = 32'h12345678;
        step();
        flush       = 1'b0;
        in_if.valid = 1'b0;
        chk("flush_fill",  fill_level,   0);
        chk("flush_valid", out_if.valid, 0);
        chk("flush_rdy",   in_if.rdy,    1);
        out_if.rdy = 1'b1;
        repeat (3) step();
        chk("flush_stays_empty", out_if.valid, 0);
        in_if.valid = 1'b1;
        in_if.data  = 32'h55;
        step();
        in_if.valid = 1'b0;
        chk("flush_after_data", out_if.data, 32'h55);
        step();
`endif

        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
